// File: rtl/tipi_nibble_port.sv
// tipi_nibble_port: Pi-facing nibble port of the TIPI CPLD.
// Serializes the TD/TC latches to the Pi and deserializes Pi writes into
// RD/RC over a 4-bit bus paced by the Pi's asynchronous r_clk strobe.
module tipi_nibble_port #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_clk,
    input  logic       r_nibrst,
    input  logic [3:0] r_nib_in,
    output logic [3:0] r_nib_out,
    output logic       r_nib_oe,
    input  logic [7:0] td_in,
    input  logic [7:0] tc_in,
    output logic [7:0] rd_out,
    output logic [7:0] rc_out,
    output logic       rd_wr,
    output logic       rc_wr,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    logic [SYNC_STAGES-1:0] rclk_sync_q;
    logic [SYNC_STAGES-1:0] nibrst_sync_q;
    logic                   rclk_prev_q;
    logic                   edge_s;
    logic                   nibrst_s;

    state_t      state_q, state_d;
    logic        is_rd_q, is_rd_d;
    logic        wr_ok_q, wr_ok_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rd_q, rd_d;
    logic [7:0]  rc_q, rc_d;
    logic        rd_wr_q, rd_wr_d;
    logic        rc_wr_q, rc_wr_d;
    logic        err_q, err_d;

    // Synchronize the asynchronous Pi strobes and remember the last strobe level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rclk_sync_q   <= '0;
            nibrst_sync_q <= '0;
            rclk_prev_q   <= 1'b0;
        end else begin
            rclk_sync_q   <= {rclk_sync_q[SYNC_STAGES-2:0], r_clk};
            nibrst_sync_q <= {nibrst_sync_q[SYNC_STAGES-2:0], r_nibrst};
            rclk_prev_q   <= rclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_s   = rclk_sync_q[SYNC_STAGES-1] & ~rclk_prev_q;
    assign nibrst_s = nibrst_sync_q[SYNC_STAGES-1];

    // Frame state and data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            wr_ok_q <= 1'b0;
            sel_q   <= '0;
            sh_q    <= '0;
            rd_q    <= '0;
            rc_q    <= '0;
            rd_wr_q <= 1'b0;
            rc_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            wr_ok_q <= wr_ok_d;
            sel_q   <= sel_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            rc_q    <= rc_d;
            rd_wr_q <= rd_wr_d;
            rc_wr_q <= rc_wr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: frame reset wins over a coincident strobe edge.
    always_comb begin
        state_d = state_q;
        is_rd_d = is_rd_q;
        wr_ok_d = wr_ok_q;
        sel_d   = sel_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        rc_d    = rc_q;
        rd_wr_d = 1'b0;
        rc_wr_d = 1'b0;
        err_d   = err_q;
        if (nibrst_s) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end else if (edge_s) begin
            unique case (state_q)
                IDLE: begin
                    // A reserved bit2 invalidates the frame in either direction.
                    is_rd_d = r_nib_in[3] & ~r_nib_in[2];
                    wr_ok_d = ~r_nib_in[3] & ~r_nib_in[2] & r_nib_in[1];
                    sel_d   = r_nib_in[1:0];
                    if (r_nib_in[2] || (!r_nib_in[3] && !r_nib_in[1]))
                        err_d = 1'b1;
                    unique case (r_nib_in[1:0])
                        2'd0:    sh_d = td_in;
                        2'd1:    sh_d = tc_in;
                        2'd2:    sh_d = rd_q;
                        default: sh_d = rc_q;
                    endcase
                    state_d = HI;
                end
                HI: begin
                    if (!is_rd_q)
                        sh_d[7:4] = r_nib_in;
                    state_d = LO;
                end
                LO: begin
                    if (!is_rd_q) begin
                        sh_d[3:0] = r_nib_in;
                        if (wr_ok_q) begin
                            if (sel_q[0]) begin
                                rc_d    = {sh_q[7:4], r_nib_in};
                                rc_wr_d = 1'b1;
                            end else begin
                                rd_d    = {sh_q[7:4], r_nib_in};
                                rd_wr_d = 1'b1;
                            end
                        end
                    end
                    state_d = DONE;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Output decode from current state.
    always_comb begin
        busy      = (state_q == HI) || (state_q == LO);
        r_nib_oe  = busy && is_rd_q;
        r_nib_out = '0;
        if (r_nib_oe)
            r_nib_out = (state_q == HI) ? sh_q[7:4] : sh_q[3:0];
    end

    assign rd_out    = rd_q;
    assign rc_out    = rc_q;
    assign rd_wr     = rd_wr_q;
    assign rc_wr     = rc_wr_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_tipi_nibble_port.sv
// Directed testbench for tipi_nibble_port with a read-nibble scoreboard.
module tb_tipi_nibble_port;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r_clk = 1'b0;
    logic       r_nibrst = 1'b0;
    logic [3:0] r_nib_in = '0;
    logic [3:0] r_nib_out;
    logic       r_nib_oe;
    logic [7:0] td_in = '0;
    logic [7:0] tc_in = '0;
    logic [7:0] rd_out, rc_out;
    logic       rd_wr, rc_wr, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int rd_wr_cnt = 0;
    int rc_wr_cnt = 0;
    logic [3:0] exp_q[$];

    tipi_nibble_port #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .r_clk(r_clk), .r_nibrst(r_nibrst),
        .r_nib_in(r_nib_in), .r_nib_out(r_nib_out), .r_nib_oe(r_nib_oe),
        .td_in(td_in), .tc_in(tc_in), .rd_out(rd_out), .rc_out(rc_out),
        .rd_wr(rd_wr), .rc_wr(rc_wr), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count write pulses as they occur.
    always @(posedge clk) begin
        if (rd_wr) rd_wr_cnt <= rd_wr_cnt + 1;
        if (rc_wr) rc_wr_cnt <= rc_wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Pi strobe: drive nibble, raise r_clk, hold, drop; returns on a negedge.
    task automatic pi_edge(input logic [3:0] nib);
        @(negedge clk);
        r_nib_in = nib;
        r_clk = 1'b1;
        repeat (6) @(negedge clk);
        r_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_reset();
        @(negedge clk);
        r_nibrst = 1'b1;
        repeat (5) @(negedge clk);
        r_nibrst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_read_nib(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_oe"}, 32'(r_nib_oe), 32'd1);
            chk(tag, 32'(r_nib_out), 32'(e));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd", 32'(rd_out), 32'h00);
        chk("rst_rc", 32'(rc_out), 32'h00);
        chk("rst_oe", 32'(r_nib_oe), 32'd0);
        chk("rst_nib", 32'(r_nib_out), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_wr", 32'(rd_wr_cnt + rc_wr_cnt), 32'd0);

        // Read TD, with TD changing mid-frame.
        td_in = 8'hA5;
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h5);
        pi_edge(4'h8);
        chk_read_nib("rdtd_hi");
        td_in = 8'h3C;
        pi_edge(4'h0);
        chk_read_nib("rdtd_lo");
        pi_edge(4'h0);
        chk("rdtd_done_oe", 32'(r_nib_oe), 32'd0);
        chk("rdtd_done_nib", 32'(r_nib_out), 32'd0);
        chk("rdtd_done_busy", 32'(busy), 32'd0);
        chk("rdtd_err", 32'(frame_err), 32'd0);
        frame_reset();

        // Write RC = 7E, then read it back.
        pi_edge(4'h3);
        pi_edge(4'h7);
        pi_edge(4'hE);
        chk("wrrc_val", 32'(rc_out), 32'h7E);
        chk("wrrc_pulse", 32'(rc_wr_cnt), 32'd1);
        chk("wrrc_rd", 32'(rd_out), 32'h00);
        chk("wrrc_rdwr", 32'(rd_wr_cnt), 32'd0);
        chk("wrrc_err", 32'(frame_err), 32'd0);
        frame_reset();
        exp_q.push_back(4'h7);
        exp_q.push_back(4'hE);
        pi_edge(4'hB);
        chk_read_nib("rdrc_hi");
        pi_edge(4'h0);
        chk_read_nib("rdrc_lo");
        pi_edge(4'h0);
        frame_reset();

        // Illegal write to TD.
        pi_edge(4'h0);
        pi_edge(4'hF);
        pi_edge(4'hF);
        chk("wrtd_err", 32'(frame_err), 32'd1);
        chk("wrtd_pulses", 32'(rd_wr_cnt + rc_wr_cnt), 32'd1);
        chk("wrtd_rd", 32'(rd_out), 32'h00);
        chk("wrtd_rc", 32'(rc_out), 32'h7E);
        frame_reset();
        chk("nibrst_err", 32'(frame_err), 32'd0);
        chk("nibrst_busy", 32'(busy), 32'd0);

        // Aborted RD write, then a full one.
        pi_edge(4'h2);
        pi_edge(4'h9);
        chk("abort_busy", 32'(busy), 32'd1);
        frame_reset();
        chk("abort_rd", 32'(rd_out), 32'h00);
        chk("abort_rdwr", 32'(rd_wr_cnt), 32'd0);
        chk("abort_busy2", 32'(busy), 32'd0);
        pi_edge(4'h2);
        pi_edge(4'h1);
        pi_edge(4'h2);
        chk("wrrd_val", 32'(rd_out), 32'h12);
        chk("wrrd_pulse", 32'(rd_wr_cnt), 32'd1);

        // Extra edge after a complete frame.
        pi_edge(4'h0);
        chk("extra_err", 32'(frame_err), 32'd1);
        chk("extra_busy", 32'(busy), 32'd0);
        chk("extra_rd", 32'(rd_out), 32'h12);

        // Frame reset coincident with a strobe: the strobe is ignored.
        @(negedge clk);
        r_nibrst = 1'b1;
        r_clk = 1'b1;
        r_nib_in = 4'h9;
        repeat (6) @(negedge clk);
        r_clk = 1'b0;
        repeat (3) @(negedge clk);
        r_nibrst = 1'b0;
        repeat (5) @(negedge clk);
        chk("coinc_err", 32'(frame_err), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd0);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        pi_edge(4'hA);
        chk_read_nib("rdrd_hi");
        pi_edge(4'h0);
        chk_read_nib("rdrd_lo");
        pi_edge(4'h0);
        chk("final_rc", 32'(rc_out), 32'h7E);
        chk("final_pulses", 32'(rd_wr_cnt + rc_wr_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tipi_nibble_port.md
# tipi_nibble_port

Pi-facing register port of the TIPI CPLD. It serializes the TI-written TD/TC latches out to the Raspberry Pi, and deserializes Pi-written RD/RC bytes in, over the 4-bit r_nib bus. The Pi paces each nibble with its asynchronous r_clk and frames transfers with r_nibrst. The block sits directly downstream of the TI-side TD/TC latches and directly upstream of the RD/RC read path in tipi_top.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in each synchronizer for r_clk and r_nibrst (minimum 2).

Ports:
- clk  in  1  CPLD system clock, at least 8x the r_clk toggle rate.
- reset  in  1  synchronous, active-low reset; one clock.
- r_clk  in  1  Pi nibble strobe, asynchronous; the rising edge advances the frame.
- r_nibrst  in  1  Pi frame reset, asynchronous, level high = hold in IDLE.
- r_nib_in  in  4  nibble from the Pi.
- r_nib_out  out  4  nibble to the Pi.
- r_nib_oe  out  1  high = block drives r_nib; the tristate lives in the top level.
- td_in  in  8  TI data latch (TD).
- tc_in  in  8  TI control latch (TC).
- rd_out  out  8  Pi data register (RD), feeding the TI read path.
- rc_out  out  8  Pi control register (RC), feeding the TI read path.
- rd_wr  out  1  one-clock pulse when rd_out updates.
- rc_wr  out  1  one-clock pulse when rc_out updates.
- frame_err  out  1  sticky protocol error; cleared by r_nibrst or reset.
- busy  out  1  high while in state HI or LO.

## Operation
- r_clk and r_nibrst each pass through a SYNC_STAGES flop chain.
- A rising edge is detected as synced=1 and previous=0. The edge pulse is one clk wide.
- Frame format: cmd nibble, hi nibble, lo nibble.
- cmd nibble layout:
  - bit3 = 1 for Pi read, 0 for Pi write.
  - bit2 reserved, must be 0.
  - bits1:0 select the register: 0 TD, 1 TC, 2 RD, 3 RC.
- State machine:
  - IDLE: on an edge, capture cmd from r_nib_in and go to HI.
    - Read: snapshot the selected 8-bit source into shadow register sh. Sources are td_in, tc_in, rd_out or rc_out.
    - Write to sel 0/1, or bit2 = 1: set frame_err; still go to HI. The data is discarded.
  - HI:
    - Read: r_nib_out = sh[7:4].
    - Write: on an edge, capture r_nib_in into sh[7:4]. Go to LO.
  - LO:
    - Read: r_nib_out = sh[3:0].
    - Write: on an edge, capture sh[3:0].
    - If valid (sel 2 or 3), load {sh[7:4], r_nib_in} into rd_out or rc_out and pulse the matching wr on the same clk.
    - Go to DONE.
  - DONE: any further edge sets frame_err and stays in DONE.
- r_nibrst synced high forces IDLE and clears frame_err. It takes priority over a simultaneous edge, which is ignored.
- r_nib_oe = 1 only in HI and LO of a read frame; 0 otherwise.
- r_nib_out = 0 whenever r_nib_oe = 0.
- rd_out and rc_out change only at a valid write's LO edge. A partial frame never alters them.

## Timing
- Reset values: state IDLE, all outputs 0.
  - rd_out = 00, rc_out = 00.
  - r_nib_oe = 0, rd_wr = 0, rc_wr = 0, frame_err = 0, busy = 0.
- Edge latency: an r_clk rise is seen as an edge pulse SYNC_STAGES+1 clk later. Register updates occur on that clk.
- Read data is valid on r_nib_out one clk after the cmd or HI edge is processed. It holds until the next edge is processed.
- The Pi must hold r_nib_in stable from its r_clk rise until SYNC_STAGES+2 clk later.
- The read snapshot is taken at the cmd edge. TI writes to TD/TC mid-frame do not tear the transfer.
- A write updates the register and pulses wr in the same clk. The new value is visible to the TI side the next clk.
- r_nibrst deasserting needs SYNC_STAGES clk before the next edge is accepted.
- reset mid-frame returns to IDLE and clears the registers. The sync chains also clear to 0.

## Test plan
- Reset, then idle: all outputs 0, state IDLE, no pulse on rd_wr or rc_wr.
- Read TD with td_in = A5: cmd 8, then two edges.
  - r_nib_out = A then 5, r_nib_oe = 1 during HI and LO, 0 in DONE.
  - Change td_in to 3C after the cmd edge: output still A, 5.
- Write RC with cmd 3, nibbles 7, E: rc_out = 7E, one rc_wr pulse, rd_out unchanged.
  - Then read RC with cmd B: returns 7, E.
- Write to TD with cmd 0, nibbles F, F: frame_err = 1, no wr pulse, rd_out and rc_out unchanged.
  - Pulse r_nibrst: frame_err clears and state is IDLE.
- Abort a write of RD after the hi nibble with r_nibrst: rd_out unchanged, no rd_wr pulse.
  - A new full write of RD with 12 gives rd_out = 12.
- Send a 4th r_clk edge after a complete frame: frame_err = 1, state stays DONE.
  - r_nibrst asserted on the same clk as an edge: IDLE, edge ignored.
